// File: rtl/bram_2ptrue_be.sv
// True dual-port block RAM with byte enables, selectable read-during-write, collision
// counting and a reset-triggered clear engine. Define BRAM_OUTREG_EN for a second read register stage.
//
// state   | meaning
// S_CLEAR | zeroing mem[ptr] each cycle, ports ignored, busy=1
// S_RUN   | normal dual-port operation
module bram_2ptrue_be #(
  parameter int DATA     = 16,
  parameter int ADDR     = 10,
  parameter int RDW_MODE = 0,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [DATA/8-1:0] a_be,
  input  logic [ADDR-1:0]   a_addr,
  input  logic [DATA-1:0]   a_write,
  output logic [DATA-1:0]   a_read,
  output logic              a_valid,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [DATA/8-1:0] b_be,
  input  logic [ADDR-1:0]   b_addr,
  input  logic [DATA-1:0]   b_write,
  output logic [DATA-1:0]   b_read,
  output logic              b_valid,
  output logic              collision,
  output logic [CNT_W-1:0]  coll_count
);
  localparam int LANES = DATA / 8;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t state, state_next;
  logic [ADDR-1:0] ptr, ptr_next;
  logic [DATA-1:0] mem [2**ADDR];

  logic run, a_wr, b_wr, coll_hit;
  logic [DATA-1:0] a_old, b_old, a_merged, b_merged, a_next, b_next;
  logic [DATA-1:0] a_rd0, b_rd0;
  logic a_v0, b_v0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      S_CLEAR: begin
        ptr_next = ptr + ADDR'(1);
        if (ptr == {ADDR{1'b1}}) state_next = S_RUN;
      end
      S_RUN:   state_next = S_RUN;
      default: state_next = S_CLEAR;
    endcase
  end

  assign busy     = (state == S_CLEAR);
  assign run      = (state == S_RUN);
  assign a_wr     = run & a_en & a_we;
  assign b_wr     = run & b_en & b_we;
  assign coll_hit = a_wr & b_wr & (a_addr == b_addr) & (|(a_be & b_be));

  // Port A is written last so it wins on overlapping lanes.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[ptr] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (b_wr && b_be[i]) mem[b_addr][8*i +: 8] <= b_write[8*i +: 8];
        if (a_wr && a_be[i]) mem[a_addr][8*i +: 8] <= a_write[8*i +: 8];
      end
    end
  end

  assign a_old = mem[a_addr];
  assign b_old = mem[b_addr];

  // Write-first only merges the port's own write; the other port's write is never visible.
  always_comb begin
    a_merged = a_old;
    b_merged = b_old;
    for (int i = 0; i < LANES; i++) begin
      if (a_be[i]) a_merged[8*i +: 8] = a_write[8*i +: 8];
      if (b_be[i]) b_merged[8*i +: 8] = b_write[8*i +: 8];
    end
  end

  assign a_next = (RDW_MODE == 1 && a_we) ? a_merged : a_old;
  assign b_next = (RDW_MODE == 1 && b_we) ? b_merged : b_old;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rd0      <= '0;
      b_rd0      <= '0;
      a_v0       <= 1'b0;
      b_v0       <= 1'b0;
      collision  <= 1'b0;
      coll_count <= '0;
    end else begin
      a_v0      <= run & a_en;
      b_v0      <= run & b_en;
      collision <= coll_hit;
      if (run && a_en) a_rd0 <= a_next;
      if (run && b_en) b_rd0 <= b_next;
      if (coll_hit && coll_count != {CNT_W{1'b1}}) coll_count <= coll_count + CNT_W'(1);
    end
  end

`ifdef BRAM_OUTREG_EN
  logic [DATA-1:0] a_rd1, b_rd1;
  logic a_v1, b_v1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rd1 <= '0;
      b_rd1 <= '0;
      a_v1  <= 1'b0;
      b_v1  <= 1'b0;
    end else begin
      a_v1 <= a_v0;
      b_v1 <= b_v0;
      if (a_v0) a_rd1 <= a_rd0;
      if (b_v0) b_rd1 <= b_rd0;
    end
  end

  assign a_read  = a_rd1;
  assign b_read  = b_rd1;
  assign a_valid = a_v1;
  assign b_valid = b_v1;
`else
  assign a_read  = a_rd0;
  assign b_read  = b_rd0;
  assign a_valid = a_v0;
  assign b_valid = b_v0;
`endif

endmodule

// File: tb/tb_bram_2ptrue_be.sv
// Directed bench for bram_2ptrue_be: one read-first and one write-first instance
// share stimulus; read latency follows BRAM_OUTREG_EN.
module tb_bram_2ptrue_be;
  localparam int DATA  = 16;
  localparam int ADDR  = 6;
  localparam int CNT_W = 8;
`ifdef BRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a_en, a_we, b_en, b_we;
  logic [DATA/8-1:0] a_be, b_be;
  logic [ADDR-1:0] a_addr, b_addr;
  logic [DATA-1:0] a_write, b_write;

  logic busy, a_valid, b_valid, collision;
  logic [DATA-1:0] a_read, b_read;
  logic [CNT_W-1:0] coll_count;
  logic busy1, a_valid1, b_valid1, collision1;
  logic [DATA-1:0] a_read1, b_read1;
  logic [CNT_W-1:0] coll_count1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_2ptrue_be #(.DATA(DATA), .ADDR(ADDR), .RDW_MODE(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .busy(busy),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_write(a_write),
    .a_read(a_read), .a_valid(a_valid),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_write(b_write),
    .b_read(b_read), .b_valid(b_valid),
    .collision(collision), .coll_count(coll_count));

  bram_2ptrue_be #(.DATA(DATA), .ADDR(ADDR), .RDW_MODE(1), .CNT_W(CNT_W)) dut_wf (
    .clk(clk), .reset(reset), .busy(busy1),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_write(a_write),
    .a_read(a_read1), .a_valid(a_valid1),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_write(b_write),
    .b_read(b_read1), .b_valid(b_valid1),
    .collision(collision1), .coll_count(coll_count1));

  task automatic idle();
    a_en = 0; a_we = 0; a_be = '0; a_addr = '0; a_write = '0;
    b_en = 0; b_we = 0; b_be = '0; b_addr = '0; b_write = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_lat();
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
  endtask

  // Counts negedge samples with busy high after reset release (bounded).
  task automatic measure_clear(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
    checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b%b want 00", a_valid, b_valid); end
    checks++; if (a_read !== 16'h0 || b_read !== 16'h0) begin errors++; $display("FAIL reset_read got %h %h want 0000 0000", a_read, b_read); end
    checks++; if (collision !== 1'b0 || coll_count !== 8'd0) begin errors++; $display("FAIL reset_coll got %b %0d want 0 0", collision, coll_count); end
    @(posedge clk); #1 reset = 0;
    measure_clear(n);
    checks++; if (n !== 64) begin errors++; $display("FAIL clear_len got %0d want 64", n); end
  endtask

  task automatic test_clear_restart();
    int n;
    a_en = 1; a_we = 1; a_be = 2'b11; a_addr = 6'h3F; a_write = 16'hFFFF;
    step(); idle();
    a_en = 1; a_addr = 6'h3F;
    step(); idle(); wait_lat();
    checks++; if (a_read !== 16'hFFFF) begin errors++; $display("FAIL pre_clear_rd got %h want ffff", a_read); end
    reset = 1; step(); reset = 0;
    repeat (20) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midclear_busy got %b want 1", busy); end
    @(posedge clk); #1 reset = 0;
    measure_clear(n);
    checks++; if (n !== 64) begin errors++; $display("FAIL restart_len got %0d want 64", n); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL restart_busy1 got %b want 0", busy1); end
    a_en = 1; a_addr = 6'h3F;
    step(); idle(); wait_lat();
    checks++; if (a_read !== 16'h0000) begin errors++; $display("FAIL cleared_rd got %h want 0000", a_read); end
    checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL cleared_valid got %b want 1", a_valid); end
    @(negedge clk);
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL valid_drop got %b want 0", a_valid); end
  endtask

  task automatic test_byte_enables();
    a_en = 1; a_we = 1; a_be = 2'b11; a_addr = 6'h05; a_write = 16'hBEEF;
    step();
    a_be = 2'b01; a_write = 16'h1234;
    step(); idle();
    b_en = 1; b_addr = 6'h05;
    step(); idle(); wait_lat();
    checks++; if (b_read !== 16'hBE34) begin errors++; $display("FAIL byte_en got %h want be34", b_read); end
    checks++; if (b_valid !== 1'b1) begin errors++; $display("FAIL byte_en_valid got %b want 1", b_valid); end
    @(negedge clk);
    checks++; if (b_valid !== 1'b0 || b_read !== 16'hBE34) begin errors++; $display("FAIL read_hold got %b %h want 0 be34", b_valid, b_read); end
  endtask

  task automatic test_rdw();
    a_en = 1; a_we = 1; a_be = 2'b11; a_addr = 6'h0A; a_write = 16'h2222;
    step();
    a_write = 16'h1111;
    step(); idle(); wait_lat();
    checks++; if (a_read !== 16'h2222) begin errors++; $display("FAIL rdw_old got %h want 2222", a_read); end
    checks++; if (a_read1 !== 16'h1111) begin errors++; $display("FAIL rdw_new got %h want 1111", a_read1); end
    a_en = 1; a_we = 1; a_be = 2'b01; a_addr = 6'h0A; a_write = 16'h3344;
    step(); idle(); wait_lat();
    checks++; if (a_read !== 16'h1111) begin errors++; $display("FAIL rdw_old_part got %h want 1111", a_read); end
    checks++; if (a_read1 !== 16'h1144) begin errors++; $display("FAIL rdw_new_part got %h want 1144", a_read1); end
  endtask

  task automatic test_cross_port();
    a_en = 1; a_we = 1; a_be = 2'b11; a_addr = 6'h10; a_write = 16'h5555;
    b_en = 1; b_addr = 6'h10;
    step(); idle(); wait_lat();
    checks++; if (b_read !== 16'h0000) begin errors++; $display("FAIL cross_old got %h want 0000", b_read); end
    checks++; if (b_read1 !== 16'h0000) begin errors++; $display("FAIL cross_old_wf got %h want 0000", b_read1); end
    checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL write_valid got %b want 1", a_valid); end
    b_en = 1; b_addr = 6'h10;
    step(); idle(); wait_lat();
    checks++; if (b_read !== 16'h5555) begin errors++; $display("FAIL cross_new got %h want 5555", b_read); end
  endtask

  task automatic test_collision();
    a_en = 1; a_we = 1; a_be = 2'b10; a_addr = 6'h20; a_write = 16'hAAAA;
    b_en = 1; b_we = 1; b_be = 2'b11; b_addr = 6'h20; b_write = 16'hBBBB;
    step(); idle();
    @(negedge clk);
    checks++; if (collision !== 1'b1) begin errors++; $display("FAIL coll_pulse got %b want 1", collision); end
    checks++; if (coll_count !== 8'd1) begin errors++; $display("FAIL coll_count1 got %0d want 1", coll_count); end
    @(negedge clk);
    checks++; if (collision !== 1'b0) begin errors++; $display("FAIL coll_width got %b want 0", collision); end
    a_en = 1; a_addr = 6'h20;
    step(); idle(); wait_lat();
    checks++; if (a_read !== 16'hAABB) begin errors++; $display("FAIL coll_data got %h want aabb", a_read); end
    a_en = 1; a_we = 1; a_be = 2'b10; a_addr = 6'h21; a_write = 16'hCCCC;
    b_en = 1; b_we = 1; b_be = 2'b01; b_addr = 6'h21; b_write = 16'hDDDD;
    step(); idle();
    @(negedge clk);
    checks++; if (collision !== 1'b0 || coll_count !== 8'd1) begin errors++; $display("FAIL no_overlap got %b %0d want 0 1", collision, coll_count); end
    a_en = 1; a_addr = 6'h21;
    step(); idle(); wait_lat();
    checks++; if (a_read !== 16'hCCDD) begin errors++; $display("FAIL merge_data got %h want ccdd", a_read); end
    a_en = 1; a_we = 1; a_be = 2'b10; a_addr = 6'h20; a_write = 16'hAAAA;
    b_en = 1; b_we = 1; b_be = 2'b11; b_addr = 6'h20; b_write = 16'hBBBB;
    repeat (299) step();
    idle();
    @(negedge clk);
    checks++; if (coll_count !== 8'd255) begin errors++; $display("FAIL coll_sat got %0d want 255", coll_count); end
    checks++; if (coll_count1 !== 8'd255) begin errors++; $display("FAIL coll_sat_wf got %0d want 255", coll_count1); end
  endtask

  task automatic test_latency();
    a_en = 1; a_addr = 6'h05;
    step(); idle();
    @(negedge clk);
    checks++; if (a_valid !== (LAT == 1)) begin errors++; $display("FAIL lat_valid1 got %b want %b", a_valid, (LAT == 1)); end
    @(negedge clk);
    checks++; if (a_valid !== (LAT == 2)) begin errors++; $display("FAIL lat_valid2 got %b want %b", a_valid, (LAT == 2)); end
    checks++; if (a_read !== 16'hBE34) begin errors++; $display("FAIL lat_data got %h want be34", a_read); end
  endtask

  initial begin
    idle();
    test_reset();
    test_clear_restart();
    test_byte_enables();
    test_rdw();
    test_cross_port();
    test_collision();
    test_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bram_2ptrue_be.md
Name: bram_2ptrue_be

Overview:
- Parametrised true dual-port synchronous block RAM. Successor to the fixed-size 2-port sync RAMs.
- Both ports can read and write, with per-byte write enables.
- Configurable read-during-write behaviour.
- Write-collision detection and counting.
- A reset-triggered clear engine zeroes the whole array.
- Used as shared CPU/peripheral buffer memory in the SoC fabric.

Parameters:
- DATA, 16, word width in bits; must be a multiple of 8.
- ADDR, 10, address width; depth is 2**ADDR words.
- RDW_MODE, 0, same-port read-during-write result: 0 = old data (read-first), 1 = new data (write-first).
- CNT_W, 8, width of the saturating collision counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- busy  out  1  high while the clear engine runs; both ports are ignored while high.
- a_en  in  1  port A access enable.
- a_we  in  1  port A write enable; qualified by a_en.
- a_be  in  DATA/8  port A byte-lane enables; bit i covers bits [8i+7:8i].
- a_addr  in  ADDR  port A word address.
- a_write  in  DATA  port A write data.
- a_read  out  DATA  port A read data.
- a_valid  out  1  port A read data valid strobe.
- b_en, b_we, b_be, b_addr, b_write, b_read, b_valid: same as port A, for port B.
- collision  out  1  one-cycle pulse: both ports wrote the same address with overlapping byte lanes.
- coll_count  out  CNT_W  saturating count of collision events.

Behaviour:
- Reset (async assert): a_read=0, b_read=0, a_valid=0, b_valid=0, collision=0, coll_count=0, busy=1, clear pointer=0, FSM enters CLEAR.
- CLEAR state:
  - Each cycle writes 0 to mem[ptr] and increments ptr.
  - On the cycle that writes ptr == 2**ADDR-1, FSM goes to RUN; busy=0 from the next cycle.
  - Clear therefore takes exactly 2**ADDR cycles after reset release.
  - Port inputs are ignored in CLEAR: no writes, valids stay 0.
- Reset asserted mid-clear or mid-RUN restarts CLEAR from ptr=0.
- RUN state, read:
  - A port read happens when x_en=1.
  - Address is registered; x_read is updated and x_valid=1 on the next cycle (latency 1).
  - x_valid=0 in any cycle following x_en=0.
  - x_read holds its last value while x_en=0.
- RUN state, write:
  - Occurs when x_en=1 and x_we=1.
  - Only lanes with x_be[i]=1 are updated.
  - A write access also produces read data with x_valid=1.
- Same-port read-during-write:
  - RDW_MODE=0: x_read returns the pre-write word.
  - RDW_MODE=1: x_read returns the merged post-write word (unenabled lanes keep old data).
- Cross-port, same address, same cycle, one port writing: the reading port always gets old data, regardless of RDW_MODE.
- Both ports writing the same address, same cycle:
  - Port A wins on overlapping lanes.
  - Port B's non-overlapping lanes are still written.
  - collision pulses 1 the next cycle if (a_be & b_be) != 0.
  - coll_count increments with that pulse and saturates at 2**CNT_W-1.
- Address arithmetic: unsigned, no wrap logic needed; the full ADDR range is valid.

Optional Feature:
- BRAM_OUTREG_EN defined: extra output register stage on a_read/b_read.
  - Read latency becomes 2; x_valid is delayed to match.
  - Output regs reset to 0.
  - collision timing is unchanged.
- Not defined: latency 1 as above, no extra registers.

Test Plan (DATA=16, ADDR=6, CNT_W=8, RDW_MODE=0 unless noted):
- Clear: release reset -> busy=1 for exactly 64 cycles, then 0; read addr 0x3F -> a_read=0x0000, a_valid=1 one cycle later. Assert reset at clear cycle 20 -> busy stays 1 for 64 cycles after the new release.
- Byte enables: A writes 0xBEEF to 0x05 with be=11, then writes 0x1234 with be=01 -> B reads 0x05 -> 0xBE34.
- Read-during-write, RDW_MODE=0: A writes 0x1111 to 0x0A holding 0x2222 -> a_read=0x2222. Same with RDW_MODE=1 -> a_read=0x1111.
- Cross-port read-during-write: A writes 0x5555 to 0x10 holding 0; B reads 0x10 in the same cycle -> b_read=0x0000; B reads next cycle -> 0x5555.
- Dual-write collision: A writes 0xAAAA with be=10, B writes 0xBBBB with be=11, both to 0x20 -> mem=0xAABB, collision=1 for 1 cycle, coll_count=1. Repeat 300 times -> coll_count=255.
- With BRAM_OUTREG_EN: A reads 0x05 -> a_valid high 2 cycles after a_en, a_read=0xBE34.
